// File: rtl/peristaltic_pump_seq.sv
// Peristaltic pump sequencer: walks a single open valve along an N-valve chain
// for a programmed number of strokes, with hold, graceful stop and abort.
module peristaltic_pump_seq #(
  parameter int NUM_VALVES = 3,
  parameter int CNT_W      = 16,
  parameter int DWELL_W    = 16,
  localparam int PH_W      = $clog2(NUM_VALVES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  dir,
  input  logic [CNT_W-1:0]      strokes,
  input  logic [DWELL_W-1:0]    dwell,
  input  logic                  hold,
  input  logic                  stop,
  input  logic                  abort,
  output logic [NUM_VALVES-1:0] valve_ctrl,
  output logic [PH_W-1:0]       phase,
  output logic [CNT_W-1:0]      stroke_cnt,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [NUM_VALVES-1:0] ALL_CLOSED = {NUM_VALVES{1'b1}};
  localparam logic [PH_W-1:0]       PH_FIRST   = {PH_W{1'b0}};
  localparam logic [PH_W-1:0]       PH_LAST    = PH_W'(NUM_VALVES - 1);

  state_t                  state, state_nx;
  logic                    dir_q, dir_nx;
  logic [CNT_W-1:0]        strokes_q, strokes_nx;
  logic [DWELL_W-1:0]      dwell_q, dwell_nx;
  logic [DWELL_W-1:0]      timer, timer_nx;
  logic                    stop_seen, stop_nx;
  logic [NUM_VALVES-1:0]   valve_nx;
  logic [PH_W-1:0]         phase_nx;
  logic [CNT_W-1:0]        cnt_nx;
  logic                    busy_nx, done_nx;

  logic                    launch, expire, last_phase, finish;
  logic [PH_W-1:0]         phase_step;
  logic [CNT_W-1:0]        cnt_inc;

  function automatic logic [NUM_VALVES-1:0] open_valve(input logic [PH_W-1:0] p);
    logic [NUM_VALVES-1:0] v;
    for (int i = 0; i < NUM_VALVES; i++) begin
      v[i] = (PH_W'(i) != p);
    end
    return v;
  endfunction

  assign launch     = (state == IDLE) && start && !abort;
  assign expire     = (timer == (dwell_q - DWELL_W'(1'b1)));
  assign last_phase = dir_q ? (phase == PH_FIRST) : (phase == PH_LAST);
  assign cnt_inc    = stroke_cnt + CNT_W'(1'b1);
  assign phase_step = dir_q ? ((phase == PH_FIRST) ? PH_LAST  : phase - PH_W'(1'b1))
                            : ((phase == PH_LAST)  ? PH_FIRST : phase + PH_W'(1'b1));
  // A pending stop counts even if it arrives on the stroke-completing cycle.
  assign finish     = expire && last_phase &&
                      (((strokes_q != {CNT_W{1'b0}}) && (cnt_inc == strokes_q)) ||
                       stop_seen || stop);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state selection; abort outranks hold, which outranks stepping.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (launch) state_nx = RUN;
        else        state_nx = IDLE;
      end
      RUN, HOLD: begin
        if (abort)       state_nx = IDLE;
        else if (hold)   state_nx = HOLD;
        else if (finish) state_nx = IDLE;
        else             state_nx = RUN;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Next values for outputs, dwell timer and run configuration.
  always_comb begin
    valve_nx   = ALL_CLOSED;
    phase_nx   = phase;
    cnt_nx     = stroke_cnt;
    busy_nx    = 1'b0;
    done_nx    = 1'b0;
    timer_nx   = timer;
    stop_nx    = stop_seen;
    dir_nx     = dir_q;
    strokes_nx = strokes_q;
    dwell_nx   = dwell_q;
    case (state)
      IDLE: begin
        stop_nx = 1'b0;
        if (launch) begin
          dir_nx     = dir;
          strokes_nx = strokes;
          dwell_nx   = (dwell == {DWELL_W{1'b0}}) ? DWELL_W'(1'b1) : dwell;
          phase_nx   = dir ? PH_LAST : PH_FIRST;
          cnt_nx     = {CNT_W{1'b0}};
          timer_nx   = {DWELL_W{1'b0}};
          valve_nx   = open_valve(phase_nx);
          busy_nx    = 1'b1;
        end else begin
          valve_nx = ALL_CLOSED;
        end
      end
      RUN, HOLD: begin
        if (abort) begin
          stop_nx = 1'b0;
        end else if (hold) begin
          stop_nx = stop_seen || stop;
          busy_nx = 1'b1;
        end else if (expire) begin
          phase_nx = phase_step;
          timer_nx = {DWELL_W{1'b0}};
          if (last_phase) cnt_nx = cnt_inc;
          else            cnt_nx = stroke_cnt;
          if (finish) begin
            stop_nx = 1'b0;
            done_nx = 1'b1;
          end else begin
            stop_nx  = stop_seen || stop;
            valve_nx = open_valve(phase_step);
            busy_nx  = 1'b1;
          end
        end else begin
          // Leaving HOLD also lands here, so the held cycle still counts toward dwell.
          timer_nx = timer + DWELL_W'(1'b1);
          stop_nx  = stop_seen || stop;
          valve_nx = open_valve(phase);
          busy_nx  = 1'b1;
        end
      end
      default: begin
        stop_nx = 1'b0;
      end
    endcase
  end

  // Registered outputs and run context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valve_ctrl <= ALL_CLOSED;
      phase      <= PH_FIRST;
      stroke_cnt <= {CNT_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      timer      <= {DWELL_W{1'b0}};
      stop_seen  <= 1'b0;
      dir_q      <= 1'b0;
      strokes_q  <= {CNT_W{1'b0}};
      dwell_q    <= DWELL_W'(1'b1);
    end else begin
      valve_ctrl <= valve_nx;
      phase      <= phase_nx;
      stroke_cnt <= cnt_nx;
      busy       <= busy_nx;
      done       <= done_nx;
      timer      <= timer_nx;
      stop_seen  <= stop_nx;
      dir_q      <= dir_nx;
      strokes_q  <= strokes_nx;
      dwell_q    <= dwell_nx;
    end
  end

endmodule

// File: tb/tb_peristaltic_pump_seq.sv
// Directed bench for peristaltic_pump_seq: a position-based run model is
// compared every cycle, and literal expectations pin key cycles of each case.
module tb_peristaltic_pump_seq;

  localparam int N = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        dir;
  logic [15:0] strokes;
  logic [15:0] dwell;
  logic        hold;
  logic        stop;
  logic        abort;
  logic [2:0]  valve_ctrl;
  logic [1:0]  phase;
  logic [15:0] stroke_cnt;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Model: a run is a count of elapsed dwell cycles since start.
  bit m_busy = 1'b0;
  bit m_held = 1'b0;
  bit m_done = 1'b0;
  bit m_stop = 1'b0;
  bit m_dir  = 1'b0;
  int m_pos  = 0;
  int m_dw   = 1;
  int m_str  = 0;
  int m_cnt  = 0;

  logic [2:0]  rv [0:63];
  logic [1:0]  rp [0:63];
  logic [15:0] rc [0:63];
  logic        rb [0:63];
  logic        rd [0:63];
  logic        done_seen;

  peristaltic_pump_seq #(.NUM_VALVES(3), .CNT_W(16), .DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .strokes(strokes),
    .dwell(dwell), .hold(hold), .stop(stop), .abort(abort),
    .valve_ctrl(valve_ctrl), .phase(phase), .stroke_cnt(stroke_cnt),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_held = 1'b0; m_stop = 1'b0; m_cnt = 0;
    end else if (!m_busy) begin
      if (start && !abort) begin
        m_busy = 1'b1; m_held = 1'b0; m_stop = 1'b0; m_pos = 0; m_cnt = 0;
        m_dir  = dir;
        m_str  = int'(strokes);
        m_dw   = (dwell == 16'd0) ? 1 : int'(dwell);
      end
    end else if (abort) begin
      m_busy = 1'b0; m_held = 1'b0; m_stop = 1'b0;
    end else if (hold) begin
      m_held = 1'b1;
      m_stop = m_stop | stop;
    end else begin
      m_held = 1'b0;
      m_stop = m_stop | stop;
      m_pos++;
      if (m_pos % (m_dw * N) == 0) begin
        m_cnt = (m_pos / (m_dw * N)) % 65536;
        if ((m_str != 0 && m_cnt == m_str) || m_stop) begin
          m_busy = 1'b0; m_done = 1'b1; m_stop = 1'b0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [2:0] ev;
    int k;
    int ph;
    ev = 3'b111;
    k  = (m_pos / m_dw) % N;
    ph = m_dir ? (N - 1 - k) : k;
    if (m_busy && !m_held) ev[ph] = 1'b0;
    chk("valve_ctrl", 32'(valve_ctrl), 32'(ev));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("stroke_cnt", 32'(stroke_cnt), 32'(m_cnt));
    chk("single_open", 32'($countones(~valve_ctrl) <= 1), 32'd1);
    if (m_busy) chk("phase", 32'(phase), 32'(ph));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  // Cycle c drives inputs; after the edge the outputs of cycle c+1 are recorded.
  task automatic run_case(input logic d, input int s, input int dw, input int len,
                          input int stop_at, input int hold_from, input int hold_to,
                          input int abort_at, input int rst_at);
    done_seen = 1'b0;
    for (int c = 0; c < len; c++) begin
      start   = (c == 0);
      dir     = d;
      strokes = 16'(s);
      dwell   = 16'(dw);
      stop    = (c == stop_at);
      hold    = (c >= hold_from) && (c <= hold_to);
      abort   = (c == abort_at);
      rst_n   = (c != rst_at);
      tick();
      rv[c+1] = valve_ctrl;
      rp[c+1] = phase;
      rc[c+1] = stroke_cnt;
      rb[c+1] = busy;
      rd[c+1] = done;
      done_seen = done_seen | done;
    end
    start = 1'b0; stop = 1'b0; hold = 1'b0; abort = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; dir = 1'b0; strokes = 16'd0; dwell = 16'd0;
    hold = 1'b0; stop = 1'b0; abort = 1'b0;
    tick();
    tick();
    chk("rst_valve", 32'(valve_ctrl), 32'h7);
    chk("rst_phase", 32'(phase), 32'h0);
    chk("rst_cnt",   32'(stroke_cnt), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    rst_n = 1'b1;
    tick();

    // forward, dwell 2, two strokes
    run_case(1'b0, 2, 2, 16, -1, -1, -2, -1, -1);
    chk("fwd_c1",   32'(rv[1]), 32'h6);
    chk("fwd_c2",   32'(rv[2]), 32'h6);
    chk("fwd_c3",   32'(rv[3]), 32'h5);
    chk("fwd_c5",   32'(rv[5]), 32'h3);
    chk("fwd_c7",   32'(rv[7]), 32'h6);
    chk("fwd_cnt7", 32'(rc[7]), 32'd1);
    chk("fwd_v13",  32'(rv[13]), 32'h7);
    chk("fwd_d12",  32'(rd[12]), 32'd0);
    chk("fwd_d13",  32'(rd[13]), 32'd1);
    chk("fwd_b13",  32'(rb[13]), 32'd0);
    chk("fwd_c13",  32'(rc[13]), 32'd2);
    chk("fwd_d14",  32'(rd[14]), 32'd0);

    // reverse, same run
    run_case(1'b1, 2, 2, 16, -1, -1, -2, -1, -1);
    chk("rev_c1",  32'(rv[1]), 32'h3);
    chk("rev_c3",  32'(rv[3]), 32'h5);
    chk("rev_c5",  32'(rv[5]), 32'h6);
    chk("rev_p1",  32'(rp[1]), 32'd2);
    chk("rev_v13", 32'(rv[13]), 32'h7);
    chk("rev_d13", 32'(rd[13]), 32'd1);

    // dwell 0 acts as 1
    run_case(1'b0, 1, 0, 7, -1, -1, -2, -1, -1);
    chk("dw0_c1", 32'(rv[1]), 32'h6);
    chk("dw0_c2", 32'(rv[2]), 32'h5);
    chk("dw0_c3", 32'(rv[3]), 32'h3);
    chk("dw0_d4", 32'(rd[4]), 32'd1);
    chk("dw0_d3", 32'(rd[3]), 32'd0);

    // continuous with stop mid stroke 2
    run_case(1'b0, 0, 1, 10, 5, -1, -2, -1, -1);
    chk("stop_v6", 32'(rv[6]), 32'h3);
    chk("stop_b6", 32'(rb[6]), 32'd1);
    chk("stop_d7", 32'(rd[7]), 32'd1);
    chk("stop_c7", 32'(rc[7]), 32'd2);

    // hold across the phase-1 dwell
    run_case(1'b0, 1, 2, 13, -1, 3, 5, -1, -1);
    chk("hold_v3",  32'(rv[3]), 32'h5);
    chk("hold_v4",  32'(rv[4]), 32'h7);
    chk("hold_v6",  32'(rv[6]), 32'h7);
    chk("hold_p5",  32'(rp[5]), 32'd1);
    chk("hold_b5",  32'(rb[5]), 32'd1);
    chk("hold_v7",  32'(rv[7]), 32'h5);
    chk("hold_v8",  32'(rv[8]), 32'h3);
    chk("hold_d9",  32'(rd[9]), 32'd0);
    chk("hold_d10", 32'(rd[10]), 32'd1);

    // abort during a run
    run_case(1'b0, 2, 2, 10, -1, -1, -2, 4, -1);
    chk("abort_b4",   32'(rb[4]), 32'd1);
    chk("abort_v5",   32'(rv[5]), 32'h7);
    chk("abort_b5",   32'(rb[5]), 32'd0);
    chk("abort_none", 32'(done_seen), 32'd0);

    // start blocked by abort in IDLE
    run_case(1'b0, 2, 2, 3, -1, -1, -2, 0, -1);
    chk("sa_b1", 32'(rb[1]), 32'd0);
    chk("sa_v1", 32'(rv[1]), 32'h7);

    // reset mid continuous run
    run_case(1'b0, 0, 1, 7, -1, -1, -2, -1, 4);
    chk("rstm_c4", 32'(rc[4]), 32'd1);
    chk("rstm_v5", 32'(rv[5]), 32'h7);
    chk("rstm_b5", 32'(rb[5]), 32'd0);
    chk("rstm_c5", 32'(rc[5]), 32'd0);
    chk("rstm_p5", 32'(rp[5]), 32'd0);
    chk("rstm_d5", 32'(rd[5]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
